alu_exec_ctrl: RTL

//  Sequencer that issues one RV32 R-/I-type ALU instruction at a time to the combinational ALU.
//  It accepts an instruction over a valid/ready handshake, decodes it and reads rs1/rs2 from
//  the register file. It then drives ALU operands and op-select, waits on multi-cycle MUL and

---
 rtl/alu_exec_ctrl.sv | 278 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: accepts one RV32 R-/I-type ALU instruction at a time, decodes it, reads
//   rs1/rs2, drives the combinational ALU and writes the result back to rd.
// Latency: rf_we/done 3 cycles after acceptance (3+MUL_LAT for MUL); illegal pulses 2 cycles after.
// Backpressure: instr_ready is high only in IDLE; instr_valid outside IDLE is ignored, not queued.
// Ports: clk/rst (sync, active-high); instr_valid/instr_ready/instr handshake;
//   rf_raddr1/2 + rf_rdata1/2 register-file read; alu_op/alu_a/alu_b/alu_y ALU interface;
//   rf_we/rf_waddr/rf_wdata write-back; done/illegal one-cycle status pulses.
// Build option: define ALU_CTRL_MUL_EN to make MUL legal and build the MUL_WAIT state/counter.
module alu_exec_ctrl #(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [31:0]     instr,
  output logic [4:0]      rf_raddr1,
  output logic [4:0]      rf_raddr2,
  input  logic [XLEN-1:0] rf_rdata1,
  input  logic [XLEN-1:0] rf_rdata2,
  output logic [3:0]      alu_op,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  input  logic [XLEN-1:0] alu_y,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            done,
  output logic            illegal
);

  if (MUL_LAT < 1 || MUL_LAT > 15) begin : g_bad_mul_lat
    $error("alu_exec_ctrl: MUL_LAT must be in 1..15");
  end

  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_I = 7'b0010011;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SLT  = 4'd6;
  localparam logic [3:0] OP_SLTU = 4'd7;
  localparam logic [3:0] OP_SLL  = 4'd8;
  localparam logic [3:0] OP_SRL  = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd10;
`ifdef ALU_CTRL_MUL_EN
  localparam logic [3:0] OP_MUL   = 4'd2;
  localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DECODE   = 3'd1,
    S_EXEC     = 3'd2,
    S_MUL_WAIT = 3'd3,
    S_WB       = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     instr_q, instr_d;
  logic [3:0]      alu_op_q, alu_op_d;
  logic [XLEN-1:0] alu_a_q, alu_a_d;
  logic [XLEN-1:0] alu_b_q, alu_b_d;
  logic            rf_we_q, rf_we_d;
  logic [4:0]      rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
  logic            done_q, done_d;
  logic            illegal_q, illegal_d;
`ifdef ALU_CTRL_MUL_EN
  logic [3:0]      cnt_q, cnt_d;
`endif

  // Instruction fields; imm[11:5] of an I-type shares bits with funct7.
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rd;
  logic [11:0]     imm;
  logic [XLEN-1:0] imm_sext;
  logic [XLEN-1:0] shamt_i;
  logic [XLEN-1:0] shamt_r;

  assign opcode   = instr_q[6:0];
  assign funct3   = instr_q[14:12];
  assign funct7   = instr_q[31:25];
  assign rd       = instr_q[11:7];
  assign imm      = instr_q[31:20];
  assign imm_sext = {{(XLEN-12){imm[11]}}, imm};
  // Shift amounts keep only the low 5 bits, zero-extended.
  assign shamt_i  = {{(XLEN-5){1'b0}}, imm[4:0]};
  assign shamt_r  = {{(XLEN-5){1'b0}}, rf_rdata2[4:0]};

  assign rf_raddr1 = instr_q[19:15];
  assign rf_raddr2 = instr_q[24:20];

  // funct3 -> ALU op; alt selects SUB/SRA over ADD/SRL.
  function automatic logic [3:0] f3_op(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? OP_SUB : OP_ADD;
      3'b001:  op = OP_SLL;
      3'b010:  op = OP_SLT;
      3'b011:  op = OP_SLTU;
      3'b100:  op = OP_XOR;
      3'b101:  op = alt ? OP_SRA : OP_SRL;
      3'b110:  op = OP_OR;
      default: op = OP_AND;
    endcase
    return op;
  endfunction

  logic            dec_legal;
  logic [3:0]      dec_op;
  logic [XLEN-1:0] dec_b;

  always_comb begin
    dec_legal = 1'b0;
    dec_op    = OP_ADD;
    dec_b     = rf_rdata2;
    case (opcode)
      OPC_R: begin
        if (funct3 == 3'b001 || funct3 == 3'b101) dec_b = shamt_r;
        if (funct7 == 7'b0000000) begin
          dec_legal = 1'b1;
          dec_op    = f3_op(funct3, 1'b0);
        end else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)) begin
          dec_legal = 1'b1;
          dec_op    = f3_op(funct3, 1'b1);
        end
`ifdef ALU_CTRL_MUL_EN
        else if (funct7 == 7'b0000001 && funct3 == 3'b000) begin
          dec_legal = 1'b1;
          dec_op    = OP_MUL;
        end
`endif
      end
      OPC_I: begin
        dec_b = imm_sext;
        case (funct3)
          3'b001: begin
            dec_b     = shamt_i;
            dec_legal = (funct7 == 7'b0000000);
            dec_op    = OP_SLL;
          end
          3'b101: begin
            dec_b     = shamt_i;
            dec_legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
            dec_op    = f3_op(funct3, funct7[5]);
          end
          default: begin
            dec_legal = 1'b1;
            dec_op    = f3_op(funct3, 1'b0);
          end
        endcase
      end
      default: ;
    endcase
  end

  logic enter_wb;

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    alu_op_d   = alu_op_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    rf_we_d    = 1'b0;
    done_d     = 1'b0;
    illegal_d  = 1'b0;
    enter_wb   = 1'b0;
`ifdef ALU_CTRL_MUL_EN
    cnt_d      = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          instr_d = instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (dec_legal) begin
          alu_op_d = dec_op;
          alu_a_d  = rf_rdata1;
          alu_b_d  = dec_b;
          state_d  = S_EXEC;
        end else begin
          illegal_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_EXEC: begin
`ifdef ALU_CTRL_MUL_EN
        if (alu_op_q == OP_MUL) begin
          cnt_d   = CNT_INIT;
          state_d = S_MUL_WAIT;
        end else begin
          rf_wdata_d = alu_y;
          enter_wb   = 1'b1;
        end
`else
        rf_wdata_d = alu_y;
        enter_wb   = 1'b1;
`endif
      end
`ifdef ALU_CTRL_MUL_EN
      S_MUL_WAIT: begin
        // Operands stay registered; the multiplier result is taken on the last wait cycle.
        if (cnt_q == 4'd0) begin
          rf_wdata_d = alu_y;
          enter_wb   = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
`endif
      S_WB: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Status pulses are registered, so they are set on the transition into WB.
    if (enter_wb) begin
      state_d    = S_WB;
      rf_we_d    = (rd != 5'd0);
      done_d     = 1'b1;
      rf_waddr_d = rd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      instr_q    <= '0;
      alu_op_q   <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
`ifdef ALU_CTRL_MUL_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      alu_op_q   <= alu_op_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      done_q     <= done_d;
      illegal_q  <= illegal_d;
`ifdef ALU_CTRL_MUL_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign instr_ready = (state_q == S_IDLE);
  assign alu_op      = alu_op_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign rf_we       = rf_we_q;
  assign rf_waddr    = rf_waddr_q;
  assign rf_wdata    = rf_wdata_q;
  assign done        = done_q;
  assign illegal     = illegal_q;

endmodule
